// File: rtl/placar_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : placar_pkg
//  Purpose  : Shared definitions for the scoreboard display scanner:
//             segment patterns (active-high, seg[0]=a .. seg[6]=g),
//             converter state encoding and digit slot indices.
//  Revision : 1.0 - initial release
// ============================================================================
package placar_pkg;

  // Segment patterns in active-high form; output polarity is applied later
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Double-dabble converter states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // Scan slot indices; the index value is also the digit_en bit position
  localparam logic [1:0] T1_TENS  = 2'd3;
  localparam logic [1:0] T1_UNITS = 2'd2;
  localparam logic [1:0] T2_TENS  = 2'd1;
  localparam logic [1:0] T2_UNITS = 2'd0;

  // Map a BCD digit to its active-high segment pattern; non-decimal values blank
  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage : placar_pkg
`default_nettype wire

// File: rtl/bin7_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : bin7_to_bcd
//  Purpose  : Sequential double-dabble converter, 7-bit binary to BCD.
//             IDLE (1 cycle, snapshot) -> SHIFT (7 cycles) -> COMMIT (1 cycle).
//             o_done is high for the COMMIT cycle with the result stable.
//  Revision : 1.0 - initial release
// ============================================================================
module bin7_to_bcd
  import placar_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [6:0] i_bin,
  output logic       o_ready,
  output logic       o_done,
  output logic [3:0] o_hundreds,
  output logic [3:0] o_tens,
  output logic [3:0] o_units
);

  localparam logic [2:0] LAST_SHIFT = 3'd6;

  conv_state_t r_state;
  conv_state_t w_state_nxt;

  logic [6:0] r_bin;
  logic [3:0] r_hun;
  logic [3:0] r_ten;
  logic [3:0] r_unit;
  logic [2:0] r_count;

  logic [3:0] w_hun_adj;
  logic [3:0] w_ten_adj;
  logic [3:0] w_unit_adj;

  // Add-3 correction applied to every working nibble before each shift
  always_comb begin
    w_hun_adj  = (r_hun  >= 4'd5) ? r_hun  + 4'd3 : r_hun;
    w_ten_adj  = (r_ten  >= 4'd5) ? r_ten  + 4'd3 : r_ten;
    w_unit_adj = (r_unit >= 4'd5) ? r_unit + 4'd3 : r_unit;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = SHIFT;
      SHIFT:   if (r_count == LAST_SHIFT) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Working registers: snapshot in IDLE, adjust-and-shift in SHIFT, hold in COMMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin   <= 7'd0;
      r_hun   <= 4'd0;
      r_ten   <= 4'd0;
      r_unit  <= 4'd0;
      r_count <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_bin   <= i_bin;
            r_hun   <= 4'd0;
            r_ten   <= 4'd0;
            r_unit  <= 4'd0;
            r_count <= 3'd0;
          end
        end
        SHIFT: begin
          {r_hun, r_ten, r_unit, r_bin} <= {w_hun_adj, w_ten_adj, w_unit_adj, r_bin} << 1;
          r_count <= r_count + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_ready    = (r_state == IDLE);
  assign o_done     = (r_state == COMMIT);
  assign o_hundreds = r_hun;
  assign o_tens     = r_ten;
  assign o_units    = r_unit;

endmodule : bin7_to_bcd
`default_nettype wire

// File: rtl/placar_display_scan.sv
`default_nettype none
// ============================================================================
//  Module   : placar_display_scan
//  Purpose  : Converts both team scores to BCD alternately and drives a
//             time-multiplexed 4-digit common-anode 7-segment display.
//  Revision : 1.0 - initial release
// ============================================================================
module placar_display_scan
  import placar_pkg::*;
#(
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter bit          BLANK_LEADING = 1'b1,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic       clock,
  input  logic       clr,
  input  logic [6:0] score_t1,
  input  logic [6:0] score_t2,
  output logic [6:0] seg,
  output logic [3:0] digit_en,
  output logic [1:0] ovf,
  output logic       valid
);

  localparam int unsigned      PRE_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [6:0]       SEG_OFF  = {7{ACTIVE_LOW}};
  localparam logic [3:0]       EN_OFF   = {4{ACTIVE_LOW}};
  localparam logic             TEAM_1   = 1'b0;

  logic             r_turn;
  logic [3:0]       r_t1_tens;
  logic [3:0]       r_t1_units;
  logic [3:0]       r_t2_tens;
  logic [3:0]       r_t2_units;
  logic [1:0]       r_ovf;
  logic             r_valid;
  logic [PRE_W-1:0] r_pre;
  logic [1:0]       r_idx;
  logic [6:0]       r_seg;
  logic [3:0]       r_en;

  logic       w_ready;
  logic       w_start;
  logic       w_done;
  logic [6:0] w_bin;
  logic [3:0] w_hundreds;
  logic [3:0] w_tens;
  logic [3:0] w_units;
  logic       w_ovf_now;

  logic       w_slot_t2;
  logic       w_slot_tens;
  logic       w_slot_ovf;
  logic [3:0] w_digit;
  logic [6:0] w_pat;
  logic [3:0] w_en;

  // Conversions run back-to-back: request a new one whenever the converter is idle
  assign w_start   = w_ready;
  assign w_bin     = (r_turn == TEAM_1) ? score_t1 : score_t2;
  assign w_ovf_now = (w_hundreds != 4'd0) || (w_tens >= 4'd10);

  bin7_to_bcd u_bcd (
    .clk        (clock),
    .rst        (clr),
    .i_start    (w_start),
    .i_bin      (w_bin),
    .o_ready    (w_ready),
    .o_done     (w_done),
    .o_hundreds (w_hundreds),
    .o_tens     (w_tens),
    .o_units    (w_units)
  );

  // Commit a finished conversion into the current team's holding registers
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      r_turn     <= TEAM_1;
      r_t1_tens  <= 4'd0;
      r_t1_units <= 4'd0;
      r_t2_tens  <= 4'd0;
      r_t2_units <= 4'd0;
      r_ovf      <= 2'b00;
      r_valid    <= 1'b0;
    end else if (w_done) begin
      if (r_turn == TEAM_1) begin
        r_t1_tens  <= w_tens;
        r_t1_units <= w_units;
      end else begin
        r_t2_tens  <= w_tens;
        r_t2_units <= w_units;
        r_valid    <= 1'b1;
      end
      r_ovf[r_turn] <= w_ovf_now;
      r_turn        <= ~r_turn;
    end
  end

  // Prescaler and scan index: index steps 3,2,1,0,3 on each terminal count
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      r_pre <= '0;
      r_idx <= T1_TENS;
    end else if (r_pre == PRE_LAST) begin
      r_pre <= '0;
      r_idx <= r_idx - 2'd1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Segment decode for the slot currently selected by the scan index
  always_comb begin
    w_slot_t2   = (r_idx == T2_TENS) || (r_idx == T2_UNITS);
    w_slot_tens = (r_idx == T1_TENS) || (r_idx == T2_TENS);
    w_slot_ovf  = w_slot_t2 ? r_ovf[1] : r_ovf[0];
    w_digit     = 4'd0;
    case (r_idx)
      T1_TENS:  w_digit = r_t1_tens;
      T1_UNITS: w_digit = r_t1_units;
      T2_TENS:  w_digit = r_t2_tens;
      default:  w_digit = r_t2_units;
    endcase
    if (w_slot_ovf)
      w_pat = SEG_DASH;
    else if (BLANK_LEADING && w_slot_tens && (w_digit == 4'd0))
      w_pat = SEG_BLANK;
    else
      w_pat = seg_pattern(w_digit);
    w_en = 4'b0001 << r_idx;
  end

  // Output registers; display stays dark until both teams have been converted
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      r_seg <= SEG_OFF;
      r_en  <= EN_OFF;
    end else if (!r_valid) begin
      r_seg <= SEG_OFF;
      r_en  <= EN_OFF;
    end else begin
      r_seg <= w_pat ^ SEG_OFF;
      r_en  <= w_en ^ EN_OFF;
    end
  end

  assign seg      = r_seg;
  assign digit_en = r_en;
  assign ovf      = r_ovf;
  assign valid    = r_valid;

endmodule : placar_display_scan
`default_nettype wire

// File: tb/tb_placar_display_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_placar_display_scan
//  Purpose  : Self-checking bench for placar_display_scan with REFRESH_DIV=4,
//             ACTIVE_LOW=1, BLANK_LEADING=1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_placar_display_scan;

  // Active-low segment codes, written out by hand
  localparam logic [6:0] N0 = 7'h40, N1 = 7'h79, N2 = 7'h24, N3 = 7'h30, N4 = 7'h19;
  localparam logic [6:0] N5 = 7'h12, N6 = 7'h02, N7 = 7'h78, N8 = 7'h00, N9 = 7'h10;
  localparam logic [6:0] DSH = 7'h3F, OFF = 7'h7F, NONE = 7'h55;

  typedef struct {
    logic [6:0] s1;
    logic [6:0] s2;
    logic [6:0] e_t1t;
    logic [6:0] e_t1u;
    logic [6:0] e_t2t;
    logic [6:0] e_t2u;
    logic [1:0] e_ovf;
  } vec_t;

  logic       clock = 1'b0;
  logic       clr = 1'b1;
  logic [6:0] score_t1 = 7'd0;
  logic [6:0] score_t2 = 7'd0;
  logic [6:0] seg;
  logic [3:0] digit_en;
  logic [1:0] ovf;
  logic       valid;

  int errors = 0;
  int checks = 0;

  vec_t       vecs [8];
  logic [3:0] seq  [4];

  placar_display_scan #(
    .REFRESH_DIV   (4),
    .BLANK_LEADING (1'b1),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .clock    (clock),
    .clr      (clr),
    .score_t1 (score_t1),
    .score_t2 (score_t2),
    .seg      (seg),
    .digit_en (digit_en),
    .ovf      (ovf),
    .valid    (valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Watch one full scan period and record what each slot displayed
  task automatic capture(output logic [6:0] c3, output logic [6:0] c2,
                         output logic [6:0] c1, output logic [6:0] c0, output int bad);
    c3 = NONE; c2 = NONE; c1 = NONE; c0 = NONE; bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      case (digit_en)
        4'b0111: c3 = seg;
        4'b1011: c2 = seg;
        4'b1101: c1 = seg;
        4'b1110: c0 = seg;
        default: bad++;
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] c3, c2, c1, c0;
    logic [3:0] prev;
    int         bad;
    bit         found;

    seq[0] = 4'b0111; seq[1] = 4'b1011; seq[2] = 4'b1101; seq[3] = 4'b1110;
    vecs[0] = '{7'd0,   7'd0,   OFF, N0,  OFF, N0,  2'b00};
    vecs[1] = '{7'd57,  7'd9,   N5,  N7,  OFF, N9,  2'b00};
    vecs[2] = '{7'd57,  7'd127, N5,  N7,  DSH, DSH, 2'b10};
    vecs[3] = '{7'd100, 7'd42,  DSH, DSH, N4,  N2,  2'b01};
    vecs[4] = '{7'd99,  7'd10,  N9,  N9,  N1,  N0,  2'b00};
    vecs[5] = '{7'd127, 7'd127, DSH, DSH, DSH, DSH, 2'b11};
    vecs[6] = '{7'd80,  7'd5,   N8,  N0,  OFF, N5,  2'b00};
    vecs[7] = '{7'd36,  7'd61,  N3,  N6,  N6,  N1,  2'b00};

    // Reset state
    clr = 1'b1; score_t1 = 7'd23; score_t2 = 7'd127;
    repeat (2) @(negedge clock);
    chk("reset_seg", seg, OFF);
    chk("reset_en", digit_en, 4'hF);
    chk("reset_ovf", ovf, 2'b00);
    chk("reset_valid", valid, 1'b0);

    // First conversions after release; t1 changes 23->45 in its 3rd SHIFT cycle
    clr = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (n == 17) chk("valid_before_18", valid, 1'b0);
      if (n == 18) chk("valid_at_18", valid, 1'b1);
      if (n <= 18) chk("dark_before_valid", digit_en, 4'hF);
      else if (digit_en == 4'b0111) chk("t1_tens_pair", seg, (n >= 28) ? N4 : N2);
      else if (digit_en == 4'b1011) chk("t1_units_pair", seg, (n >= 28) ? N5 : N3);
      else if (digit_en == 4'b1101) chk("t2_tens_dash", seg, DSH);
      else if (digit_en == 4'b1110) chk("t2_units_dash", seg, DSH);
      else chk("one_digit_enabled", digit_en, 4'b0111);
      if (n == 3) score_t1 = 7'd45;
    end
    chk("ovf_t2_set", ovf, 2'b10);
    chk("valid_held", valid, 1'b1);

    // One-cycle reset in mid-SHIFT of a team 1 conversion
    clr = 1'b1;
    #1;
    chk("midreset_seg", seg, OFF);
    chk("midreset_en", digit_en, 4'hF);
    chk("midreset_ovf", ovf, 2'b00);
    chk("midreset_valid", valid, 1'b0);
    @(negedge clock);
    clr = 1'b0;
    for (int m = 1; m <= 18; m++) begin
      @(negedge clock);
      if (m == 17) chk("revalid_before_18", valid, 1'b0);
      if (m == 18) chk("revalid_at_18", valid, 1'b1);
    end

    // Scan order and dwell: sync on the 1110 -> 0111 wrap, then 16 cycles
    prev = digit_en; found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clock);
      if (digit_en == 4'b0111 && prev == 4'b1110) found = 1'b1;
      else prev = digit_en;
    end
    chk("scan_sync_found", {31'd0, found}, 32'd1);
    if (found) begin
      for (int i = 0; i < 16; i++) begin
        if (i > 0) @(negedge clock);
        chk("scan_seq", digit_en, seq[i/4]);
      end
    end

    // Table-driven score patterns
    for (int v = 0; v < 8; v++) begin
      score_t1 = vecs[v].s1;
      score_t2 = vecs[v].s2;
      repeat (40) @(negedge clock);
      capture(c3, c2, c1, c0, bad);
      chk($sformatf("v%0d_t1_tens", v), c3, vecs[v].e_t1t);
      chk($sformatf("v%0d_t1_units", v), c2, vecs[v].e_t1u);
      chk($sformatf("v%0d_t2_tens", v), c1, vecs[v].e_t2t);
      chk($sformatf("v%0d_t2_units", v), c0, vecs[v].e_t2u);
      chk($sformatf("v%0d_ovf", v), ovf, vecs[v].e_ovf);
      chk($sformatf("v%0d_onehot", v), bad, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_placar_display_scan
`default_nettype wire
